// File: rtl/parking_gate_ctrl_if.sv
// ============================================================================
//  Module      : parking_gate_ctrl_if
//  Description : Gate-side and datapath-side signal bundle of the entry-gate
//                scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface parking_gate_ctrl_if #(
    parameter int ENTRY_GATES = 3,
    parameter int SPOTS       = 64,
    parameter int CNT_W       = $clog2(SPOTS + 1)
);
    logic [ENTRY_GATES-1:0] gate_req;
    logic [SPOTS-1:0]       car_exiting_spots;
    logic [ENTRY_GATES-1:0] car_incoming;
    logic [ENTRY_GATES-1:0] gate_open;
    logic [CNT_W-1:0]       free_count;
    logic                   lot_full;

    modport master (
        output gate_req,
        output car_exiting_spots,
        input  car_incoming,
        input  gate_open,
        input  free_count,
        input  lot_full
    );

    modport slave (
        input  gate_req,
        input  car_exiting_spots,
        output car_incoming,
        output gate_open,
        output free_count,
        output lot_full
    );
endinterface

`default_nettype wire

// File: rtl/parking_gate_ctrl.sv
// ============================================================================
//  Module      : parking_gate_ctrl
//  Description : Entry-gate scheduler: free-spot accounting, round-robin
//                admission and per-gate barrier sequencing.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module parking_gate_ctrl #(
    parameter int ENTRY_GATES = 3,
    parameter int SPOTS       = 64,
    parameter int OPEN_CYCLES = 4,
    parameter int CNT_W       = $clog2(SPOTS + 1)
) (
    input wire logic           clock,
    input wire logic           reset,
    parking_gate_ctrl_if.slave bus
);

    localparam int PTR_W = (ENTRY_GATES > 1) ? $clog2(ENTRY_GATES) : 1;
    localparam int OC_W  = $clog2(OPEN_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OPEN  = 2'd1,
        ST_CLEAR = 2'd2
    } gate_state_t;

    logic [CNT_W-1:0]       r_free_count;
    logic [PTR_W-1:0]       r_rr_ptr;

    logic [ENTRY_GATES-1:0] w_idle;
    logic [ENTRY_GATES-1:0] w_eligible;
    logic [ENTRY_GATES-1:0] w_grant;
    logic [ENTRY_GATES-1:0] w_first_open;
    logic [ENTRY_GATES-1:0] w_gate_open;
    logic [CNT_W-1:0]       w_n_grant;
    logic [PTR_W-1:0]       w_rr_nxt;
    logic [PTR_W:0]         w_idx;
    logic [CNT_W-1:0]       w_exit_cnt;
    logic [CNT_W:0]         w_free_sum;
    logic [CNT_W-1:0]       w_free_nxt;

    assign w_eligible = w_idle & bus.gate_req;

    // Round-robin scan from rr_ptr; the grant count is capped by free spots,
    // so the counter below can never underflow.
    always_comb begin
        w_grant   = '0;
        w_n_grant = '0;
        w_rr_nxt  = r_rr_ptr;
        w_idx     = '0;
        for (int k = 0; k < ENTRY_GATES; k++) begin
            w_idx = {1'b0, r_rr_ptr} + (PTR_W+1)'(k);
            if (w_idx >= (PTR_W+1)'(ENTRY_GATES)) begin
                w_idx = w_idx - (PTR_W+1)'(ENTRY_GATES);
            end
            if (w_eligible[w_idx[PTR_W-1:0]] && (w_n_grant < r_free_count)) begin
                w_grant[w_idx[PTR_W-1:0]] = 1'b1;
                w_n_grant = w_n_grant + CNT_W'(1);
                w_rr_nxt  = (w_idx[PTR_W-1:0] == PTR_W'(ENTRY_GATES - 1))
                          ? '0 : (w_idx[PTR_W-1:0] + PTR_W'(1));
            end
        end
    end

    always_comb begin
        w_exit_cnt = '0;
        for (int s = 0; s < SPOTS; s++) begin
            w_exit_cnt = w_exit_cnt + CNT_W'(bus.car_exiting_spots[s]);
        end
    end

    // One extra bit of headroom so spurious exits saturate instead of wrapping.
    always_comb begin
        w_free_sum = {1'b0, r_free_count} - {1'b0, w_n_grant} + {1'b0, w_exit_cnt};
        w_free_nxt = w_free_sum[CNT_W-1:0];
        if (w_free_sum > (CNT_W+1)'(SPOTS)) begin
            w_free_nxt = CNT_W'(SPOTS);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_free_count <= CNT_W'(SPOTS);
            r_rr_ptr     <= '0;
        end else begin
            r_free_count <= w_free_nxt;
            r_rr_ptr     <= w_rr_nxt;
        end
    end

    for (genvar g = 0; g < ENTRY_GATES; g++) begin : g_gate
        gate_state_t       r_state;
        gate_state_t       w_state_nxt;
        logic [OC_W-1:0]   r_hold;
        logic [OC_W-1:0]   w_hold_nxt;

        always_ff @(posedge clock) begin
            if (!reset) begin
                r_state <= ST_IDLE;
                r_hold  <= '0;
            end else begin
                r_state <= w_state_nxt;
                r_hold  <= w_hold_nxt;
            end
        end

        // r_hold counts remaining open cycles; it is loaded on grant so the
        // barrier stays up for exactly OPEN_CYCLES cycles.
        always_comb begin
            w_state_nxt = r_state;
            w_hold_nxt  = r_hold;
            unique case (r_state)
                ST_IDLE: begin
                    if (w_grant[g]) begin
                        w_state_nxt = ST_OPEN;
                        w_hold_nxt  = OC_W'(OPEN_CYCLES - 1);
                    end
                end
                ST_OPEN: begin
                    if (r_hold == '0) begin
                        w_state_nxt = ST_CLEAR;
                    end else begin
                        w_hold_nxt = r_hold - OC_W'(1);
                    end
                end
                ST_CLEAR: begin
                    if (!bus.gate_req[g]) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_hold_nxt  = '0;
                end
            endcase
        end

        assign w_idle[g]       = (r_state == ST_IDLE);
        assign w_gate_open[g]  = (r_state == ST_OPEN);
        assign w_first_open[g] = (r_state == ST_OPEN) && (r_hold == OC_W'(OPEN_CYCLES - 1));
    end

    assign bus.car_incoming = w_first_open;
    assign bus.gate_open    = w_gate_open;
    assign bus.free_count   = r_free_count;
    assign bus.lot_full     = (r_free_count == '0);

endmodule

`default_nettype wire

// File: tb/tb_parking_gate_ctrl.sv
// ============================================================================
//  Module      : tb_parking_gate_ctrl
//  Description : Self-checking bench for parking_gate_ctrl with a
//                timestamp-based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_parking_gate_ctrl;
    localparam int G  = 3;
    localparam int S  = 64;
    localparam int OC = 4;
    localparam int CW = $clog2(S + 1);

    logic clock = 1'b0;
    logic reset = 1'b0;

    parking_gate_ctrl_if #(.ENTRY_GATES(G), .SPOTS(S), .CNT_W(CW)) bus ();

    parking_gate_ctrl #(.ENTRY_GATES(G), .SPOTS(S), .OPEN_CYCLES(OC), .CNT_W(CW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int fails  = 0;

    // Model: a gate is described by the cycle it was admitted in and whether
    // its car has been seen to leave the barrier since.
    int cyc    = 0;
    int m_free = S;
    int m_rr   = 0;
    int m_ta   [G];
    bit m_rel  [G];

    task automatic model_reset();
        for (int g = 0; g < G; g++) begin
            m_ta[g]  = -1000;
            m_rel[g] = 1'b1;
        end
        m_free = S;
        m_rr   = 0;
    endtask

    function automatic logic [G-1:0] exp_open();
        logic [G-1:0] v;
        v = '0;
        for (int g = 0; g < G; g++) v[g] = (cyc >= m_ta[g] + 1) && (cyc <= m_ta[g] + OC);
        return v;
    endfunction

    function automatic logic [G-1:0] exp_inc();
        logic [G-1:0] v;
        v = '0;
        for (int g = 0; g < G; g++) v[g] = (cyc == m_ta[g] + 1);
        return v;
    endfunction

    task automatic tick();
        logic [G-1:0] req;
        int           pop;
        int           n;
        logic         rst_s;
        int           elig[$];
        req   = bus.gate_req;
        pop   = $countones(bus.car_exiting_spots);
        rst_s = reset;
        for (int k = 0; k < G; k++) begin
            if (m_rel[(m_rr + k) % G] && req[(m_rr + k) % G]) elig.push_back((m_rr + k) % G);
        end
        n = (elig.size() < m_free) ? elig.size() : m_free;
        @(posedge clock);
        if (!rst_s) begin
            model_reset();
        end else begin
            for (int g = 0; g < G; g++) begin
                if (!m_rel[g] && (cyc > m_ta[g] + OC) && !req[g]) m_rel[g] = 1'b1;
            end
            for (int i = 0; i < n; i++) begin
                m_ta[elig[i]]  = cyc;
                m_rel[elig[i]] = 1'b0;
            end
            if (n > 0) m_rr = (elig[n-1] + 1) % G;
            m_free = m_free - n + pop;
            if (m_free > S) m_free = S;
        end
        cyc++;
        #1;
    endtask

    task automatic do_reset();
        reset                 = 1'b0;
        bus.gate_req          = '0;
        bus.car_exiting_spots = '0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset        = 1'b0;
        bus.gate_req = 3'b111;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if ({bus.car_incoming, bus.gate_open, bus.free_count, bus.lot_full}
                !== {3'b000, 3'b000, 7'd64, 1'b0}) begin
                fails++;
                $display("FAIL reset_state cyc%0d: inc=%b open=%b free=%0d full=%b, required inc=000 open=000 free=64 full=0",
                         i, bus.car_incoming, bus.gate_open, bus.free_count, bus.lot_full);
            end
        end
        bus.gate_req = '0;
        reset        = 1'b1;
    endtask

    task automatic test_single_car();
        logic [G-1:0] want_inc;
        logic [G-1:0] want_open;
        do_reset();
        bus.gate_req = 3'b010;
        for (int i = 1; i <= OC + 3; i++) begin
            tick();
            want_inc  = (i == 1) ? 3'b010 : 3'b000;
            want_open = (i <= OC) ? 3'b010 : 3'b000;
            checks++;
            if ({bus.car_incoming, bus.gate_open, bus.free_count} !== {want_inc, want_open, 7'd63}) begin
                fails++;
                $display("FAIL single_car t+%0d: inc=%b open=%b free=%0d, required inc=%b open=%b free=63",
                         i, bus.car_incoming, bus.gate_open, bus.free_count, want_inc, want_open);
            end
        end
        bus.gate_req = 3'b000;
        tick();
        bus.gate_req = 3'b010;
        tick();
        checks++;
        if ({bus.car_incoming, bus.free_count} !== {3'b010, 7'd62}) begin
            fails++;
            $display("FAIL single_car_readmit: inc=%b free=%0d, required inc=010 free=62",
                     bus.car_incoming, bus.free_count);
        end
        bus.gate_req = 3'b000;
    endtask

    task automatic test_scarcity_and_full();
        do_reset();
        for (int r = 0; r < 21; r++) begin
            bus.gate_req = 3'b111;
            tick();
            bus.gate_req = 3'b000;
            repeat (OC + 1) tick();
        end
        bus.car_exiting_spots = 64'h1;
        tick();
        bus.car_exiting_spots = '0;
        checks++;
        if (bus.free_count !== 7'd2) begin
            fails++;
            $display("FAIL scarcity_setup: free=%0d, required 2", bus.free_count);
        end
        bus.gate_req = 3'b111;
        tick();
        checks++;
        if ({bus.car_incoming, bus.gate_open, bus.free_count, bus.lot_full}
            !== {3'b011, 3'b011, 7'd0, 1'b1}) begin
            fails++;
            $display("FAIL scarcity_grant: inc=%b open=%b free=%0d full=%b, required inc=011 open=011 free=0 full=1",
                     bus.car_incoming, bus.gate_open, bus.free_count, bus.lot_full);
        end
        tick();
        checks++;
        if ({bus.car_incoming, bus.free_count} !== {3'b000, 7'd0}) begin
            fails++;
            $display("FAIL scarcity_blocked: inc=%b free=%0d, required inc=000 free=0",
                     bus.car_incoming, bus.free_count);
        end
        bus.car_exiting_spots = 64'h20;
        tick();
        bus.car_exiting_spots = '0;
        checks++;
        if ({bus.car_incoming, bus.free_count} !== {3'b000, 7'd1}) begin
            fails++;
            $display("FAIL scarcity_exit: inc=%b free=%0d, required inc=000 free=1",
                     bus.car_incoming, bus.free_count);
        end
        tick();
        checks++;
        if ({bus.car_incoming, bus.free_count, bus.lot_full} !== {3'b100, 7'd0, 1'b1}) begin
            fails++;
            $display("FAIL scarcity_gate2: inc=%b free=%0d full=%b, required inc=100 free=0 full=1",
                     bus.car_incoming, bus.free_count, bus.lot_full);
        end
        bus.gate_req = 3'b000;
        repeat (OC + 2) tick();
        bus.gate_req          = 3'b001;
        bus.car_exiting_spots = 64'h8000_0000_0000_0000;
        tick();
        bus.car_exiting_spots = '0;
        checks++;
        if ({bus.car_incoming, bus.free_count, bus.lot_full} !== {3'b000, 7'd1, 1'b0}) begin
            fails++;
            $display("FAIL full_exit_t1: inc=%b free=%0d full=%b, required inc=000 free=1 full=0",
                     bus.car_incoming, bus.free_count, bus.lot_full);
        end
        tick();
        checks++;
        if ({bus.car_incoming, bus.free_count, bus.lot_full} !== {3'b001, 7'd0, 1'b1}) begin
            fails++;
            $display("FAIL full_exit_t2: inc=%b free=%0d full=%b, required inc=001 free=0 full=1",
                     bus.car_incoming, bus.free_count, bus.lot_full);
        end
        bus.gate_req = 3'b000;
    endtask

    task automatic test_saturation();
        do_reset();
        bus.car_exiting_spots = 64'h3;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if ({bus.free_count, bus.lot_full} !== {7'd64, 1'b0}) begin
                fails++;
                $display("FAIL saturation cyc%0d: free=%0d full=%b, required free=64 full=0",
                         i, bus.free_count, bus.lot_full);
            end
        end
        bus.car_exiting_spots = '0;
    endtask

    task automatic test_reset_mid_open();
        do_reset();
        bus.gate_req = 3'b111;
        tick();
        bus.gate_req = 3'b000;
        repeat (OC + 1) tick();
        bus.gate_req = 3'b001;
        tick();
        checks++;
        if ({bus.gate_open, bus.free_count} !== {3'b001, 7'd60}) begin
            fails++;
            $display("FAIL mid_open_setup: open=%b free=%0d, required open=001 free=60",
                     bus.gate_open, bus.free_count);
        end
        tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        checks++;
        if ({bus.car_incoming, bus.gate_open, bus.free_count} !== {3'b000, 3'b000, 7'd64}) begin
            fails++;
            $display("FAIL mid_open_reset: inc=%b open=%b free=%0d, required inc=000 open=000 free=64",
                     bus.car_incoming, bus.gate_open, bus.free_count);
        end
        tick();
        checks++;
        if ({bus.car_incoming, bus.free_count} !== {3'b001, 7'd63}) begin
            fails++;
            $display("FAIL mid_open_idle: inc=%b free=%0d, required inc=001 free=63",
                     bus.car_incoming, bus.free_count);
        end
        bus.gate_req = 3'b000;
    endtask

    task automatic test_random();
        logic [G-1:0] ei;
        logic [G-1:0] eo;
        do_reset();
        for (int i = 0; i < 1200; i++) begin
            for (int g = 0; g < G; g++) begin
                if ($urandom_range(0, 3) == 0) bus.gate_req[g] = ~bus.gate_req[g];
            end
            bus.car_exiting_spots = '0;
            if ($urandom_range(0, (i < 600) ? 9 : 1) == 0) begin
                bus.car_exiting_spots[$urandom_range(0, S-1)] = 1'b1;
                if ($urandom_range(0, 3) == 0) bus.car_exiting_spots[$urandom_range(0, S-1)] = 1'b1;
            end
            reset = ($urandom_range(0, 199) != 0);
            tick();
            ei = exp_inc();
            eo = exp_open();
            checks++;
            if (bus.car_incoming !== ei) begin
                fails++;
                $display("FAIL rand_incoming cyc=%0d: got %b, required %b", cyc, bus.car_incoming, ei);
            end
            checks++;
            if (bus.gate_open !== eo) begin
                fails++;
                $display("FAIL rand_gate_open cyc=%0d: got %b, required %b", cyc, bus.gate_open, eo);
            end
            checks++;
            if (bus.free_count !== CW'(m_free)) begin
                fails++;
                $display("FAIL rand_free_count cyc=%0d: got %0d, required %0d", cyc, bus.free_count, m_free);
            end
            checks++;
            if (bus.lot_full !== (m_free == 0)) begin
                fails++;
                $display("FAIL rand_lot_full cyc=%0d: got %b, required %b", cyc, bus.lot_full, (m_free == 0));
            end
        end
        reset                 = 1'b1;
        bus.gate_req          = '0;
        bus.car_exiting_spots = '0;
    endtask

    initial begin
        model_reset();
        bus.gate_req          = '0;
        bus.car_exiting_spots = '0;
        test_reset();
        test_single_car();
        test_scarcity_and_full();
        test_saturation();
        test_reset_mid_open();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

`default_nettype wire
